// File: rtl/parallel_sc_decoder_4x.sv
// Stochastic-to-binary decoder: counts ones over a window of 4-bit beats.
// Ports: clk, reset_n, start, clear, bits_in/bits_valid in; busy, done, count_out out.
module parallel_sc_decoder_4x #(
    parameter int WINDOW_CYCLES = 15,
    parameter int COUNT_WIDTH   = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   clear,
    input  logic [3:0]             bits_in,
    input  logic                   bits_valid,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] count_out
);

    localparam int BW = $clog2(WINDOW_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [2:0]             pop;
    logic [COUNT_WIDTH-1:0] sum;
    logic                   last;

    assign pop  = 3'(bits_in[0]) + 3'(bits_in[1])
                + 3'(bits_in[2]) + 3'(bits_in[3]);
    assign sum  = acc_q + COUNT_WIDTH'(pop);
    // beat_q holds beats already taken, so the final beat sees W-1
    assign last = (beat_q == BW'(WINDOW_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        beat_d  = beat_q;
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            beat_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_ACCUM;
                        acc_d   = '0;
                        beat_d  = '0;
                    end
                end
                S_ACCUM: begin
                    if (bits_valid) begin
                        acc_d = sum;
                        if (last) begin
                            count_d = sum;
                            beat_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_d = S_ACCUM;
                        acc_d   = '0;
                        beat_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            beat_q  <= beat_d;
        end
    end

    assign busy      = (state_q == S_ACCUM);
    assign done      = (state_q == S_DONE);
    assign count_out = count_q;

endmodule

// File: doc/parallel_sc_decoder_4x.md
Name: parallel_sc_decoder_4x

Overview:
- Stochastic-to-binary decoder for 4-bit-parallel stochastic bitstreams.
- Upstream, a 4x parallel LFSR and comparator array emit 4 stochastic bits per clock. This block counts ones over a fixed window of valid beats and returns the binary estimate.
- It sits at the output end of a stochastic computing datapath.
- Conversion is start-triggered, with a busy flag and a one-cycle done pulse.

Parameters:
- WINDOW_CYCLES, 15, number of valid 4-bit beats per conversion. Default gives 60 samples, so a 4-bit LFSR state is visited exactly 4 times.
- COUNT_WIDTH, 6, width of the accumulator and result. Must satisfy 2^COUNT_WIDTH > 4*WINDOW_CYCLES.

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a new conversion; sampled in IDLE or DONE only.
- clear  input  1  synchronous abort; returns to IDLE.
- bits_in  input  4  four stochastic bits of the current beat.
- bits_valid  input  1  bits_in carries a beat this cycle.
- busy  output  1  high while in ACCUM.
- done  output  1  one-cycle pulse; count_out updated in the same cycle.
- count_out  output  COUNT_WIDTH  ones count of the last completed window.

Behaviour:
- Reset (reset_n low, async): state=IDLE, busy=0, done=0, count_out=0, accumulator=0, beat counter=0.
- States:
  - IDLE: start -> ACCUM (clear accumulator and beat counter).
  - ACCUM: on each bits_valid=1 cycle, add popcount(bits_in) (0..4) to the accumulator and increment the beat counter.
    - If that beat is beat number WINDOW_CYCLES: count_out <= accumulator + popcount, beat counter <= 0, state -> DONE.
    - bits_valid=0 cycles are gaps. Nothing is counted and the window does not advance.
  - DONE: done=1 for exactly this cycle.
    - start -> ACCUM (back-to-back, accumulator cleared).
    - Otherwise -> IDLE.
- Start timing: beats are counted only from the cycle after start is accepted. bits_valid in the same cycle as start, or in IDLE/DONE, is ignored.
- start during ACCUM is ignored; no restart.
- Latency: start at cycle 0, then WINDOW_CYCLES consecutive valid beats in cycles 1..W, then done=1 in cycle W+1.
- busy=1 exactly while state=ACCUM, i.e. from the cycle after start through the cycle of the last beat.
- clear (any state) -> IDLE next cycle: accumulator and beat counter zeroed, count_out retained, no done pulse. clear has priority over start and over bits_valid.
- count_out holds its value between done pulses; it changes only at window completion or reset.
- Arithmetic is unsigned. With a valid parameter choice the accumulator cannot overflow, so there is no saturation logic.
- Async reset mid-ACCUM: immediate return to reset values; partial count discarded.
- Popcount and the accumulate are combinational into the accumulator register; no added pipeline stage.

Test Plan:
- Release reset, start, then 15 consecutive beats of bits_in=4'b1111 -> busy high 15 cycles; done pulses in cycle 16; count_out=60.
- start, then 15 beats of 4'b0101 with bits_valid low on alternate cycles (gaps) -> done one cycle after the 15th valid beat; count_out=30; gaps not counted.
- start with bits_valid=1 and bits_in=4'b1111 in the start cycle, then 15 beats of 4'b0000 -> count_out=0; start-cycle beat ignored.
- Two windows back-to-back: 4'b0001 x15, then start asserted in the DONE cycle, then 4'b0111 x15 -> count_out=15 then 45; second done exactly 16 cycles after the first.
- Mid-window: after 7 beats of 4'b1111, assert clear -> IDLE, no done, count_out keeps its previous value. Repeat with reset_n low instead -> busy=0, done=0, count_out=0 immediately.
- Pulse start every cycle during ACCUM -> window not restarted; single done after 15 beats with correct count.
